// File: rtl/thermocouple_pkg.sv
// thermocouple_pkg
//   Shared definitions for the thermocouple readers: scanner FSM states,
//   bit positions of the fields inside the 32-bit converter frame, and the
//   widths of the decoded fields.
package thermocouple_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_REQUEST = 2'd1,
    ST_BUSY    = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int FRAME_W = 32;

  // Thermocouple temperature occupies frame[31:18].
  localparam int TC_MSB = 31;
  localparam int TC_LSB = 18;
  localparam int TC_W   = TC_MSB - TC_LSB + 1;

  // Cold-junction temperature occupies frame[15:4].
  localparam int JT_MSB = 15;
  localparam int JT_LSB = 4;
  localparam int JT_W   = JT_MSB - JT_LSB + 1;

  // frame[16] is the summary fault flag; frame[2:0] are the detailed faults.
  localparam int FAULT_BIT     = 16;
  localparam int FAULT_DET_MSB = 2;
  localparam int FAULT_W       = 4;

endpackage

// File: rtl/tc_frame_decode.sv
// tc_frame_decode
//   Purely combinational slicing of one converter frame into its fields.
//   Ports:
//     frame       in  32  raw frame from the SPI master
//     tc_temp     out 14  thermocouple temperature, frame[31:18]
//     junc_temp   out 12  junction temperature, frame[15:4]
//     fault       out 4   {summary fault frame[16], detail faults frame[2:0]}
module tc_frame_decode
  import thermocouple_pkg::*;
(
  input  logic [FRAME_W-1:0] frame,
  output logic [TC_W-1:0]    tc_temp,
  output logic [JT_W-1:0]    junc_temp,
  output logic [FAULT_W-1:0] fault
);

  assign tc_temp   = frame[TC_MSB:TC_LSB];
  assign junc_temp = frame[JT_MSB:JT_LSB];
  assign fault     = {frame[FAULT_BIT], frame[FAULT_DET_MSB:0]};

  // frame[17] and frame[3] are reserved bits in the converter frame.
  logic unused_reserved;
  assign unused_reserved = ^{frame[17], frame[3]};

endmodule

// File: rtl/thermocouple_scanner.sv
// thermocouple_scanner
//   Waits a settle delay after reset, then visits NCH converters in
//   round-robin order through a shared SPI master, producing one decoded
//   sample (or a timeout strobe) per channel visit.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     spi_not_busy        SPI master idle; spi_rx_data valid while high
//     spi_rx_data [31:0]  last received frame
//     spi_ena             transaction request to the SPI master
//     spi_sel [CHW]       chip select index of the current channel
//     tc_temp_data [14]   captured thermocouple temperature
//     junction_temp_data [12] captured junction temperature
//     fault_bits [4]      captured {frame[16], frame[2:0]}
//     sample_ch [CHW]     channel of the captured sample
//     sample_valid        one-cycle strobe per captured sample
//     fault_mask [NCH]    sticky per-channel fault (frame[16] or timeout)
//     timeout_err         one-cycle strobe when a transaction times out
module thermocouple_scanner
  import thermocouple_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int STARTUP_CYCLES = 600,
  parameter int PERIOD_CYCLES  = 200,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CBITS          = 10,
  parameter int CHW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_not_busy,
  input  logic [FRAME_W-1:0] spi_rx_data,
  output logic               spi_ena,
  output logic [CHW-1:0]     spi_sel,
  output logic [TC_W-1:0]    tc_temp_data,
  output logic [JT_W-1:0]    junction_temp_data,
  output logic [FAULT_W-1:0] fault_bits,
  output logic [CHW-1:0]     sample_ch,
  output logic               sample_valid,
  output logic [NCH-1:0]     fault_mask,
  output logic               timeout_err
);

  // Each phase ends on the edge where the counter would reach its limit,
  // so a phase of N cycles compares against N-1.
  localparam logic [CBITS-1:0] STARTUP_LAST = CBITS'(STARTUP_CYCLES - 1);
  localparam logic [CBITS-1:0] PERIOD_LAST  = CBITS'(PERIOD_CYCLES - 1);
  localparam logic [CBITS-1:0] TIMEOUT_LAST = CBITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CHW-1:0]   LAST_CH      = CHW'(NCH - 1);

  state_t           state, state_d;
  logic [CBITS-1:0] cnt, cnt_d;
  logic [CHW-1:0]   ch, ch_d;
  logic [NCH-1:0]   mask_d;
  logic             ena_d, capture, valid_d, timeout_d;

  logic [TC_W-1:0]    dec_tc;
  logic [JT_W-1:0]    dec_jt;
  logic [FAULT_W-1:0] dec_fault;

  tc_frame_decode u_decode (
    .frame     (spi_rx_data),
    .tc_temp   (dec_tc),
    .junc_temp (dec_jt),
    .fault     (dec_fault)
  );

  assign spi_sel = ch;

  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ch_d      = ch;
    mask_d    = fault_mask;
    ena_d     = 1'b0;
    capture   = 1'b0;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    case (state)
      ST_STARTUP: begin
        if (cnt == STARTUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_REQUEST;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_REQUEST: begin
        if (spi_not_busy) begin
          ena_d = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A frame arriving on the timeout edge still counts as a capture.
        if (spi_not_busy) begin
          capture    = 1'b1;
          valid_d    = 1'b1;
          mask_d[ch] = fault_mask[ch] | dec_fault[FAULT_W-1];
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_d  = 1'b1;
          mask_d[ch] = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt == PERIOD_LAST) begin
          cnt_d   = '0;
          ch_d    = (ch == LAST_CH) ? '0 : ch + 1'b1;
          state_d = ST_REQUEST;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_REQUEST;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_STARTUP;
      cnt                <= '0;
      ch                 <= '0;
      spi_ena            <= 1'b0;
      tc_temp_data       <= '0;
      junction_temp_data <= '0;
      fault_bits         <= '0;
      sample_ch          <= '0;
      sample_valid       <= 1'b0;
      fault_mask         <= '0;
      timeout_err        <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      ch           <= ch_d;
      spi_ena      <= ena_d;
      sample_valid <= valid_d;
      timeout_err  <= timeout_d;
      fault_mask   <= mask_d;
      if (capture) begin
        tc_temp_data       <= dec_tc;
        junction_temp_data <= dec_jt;
        fault_bits         <= dec_fault;
        sample_ch          <= ch;
      end
    end
  end

endmodule

// File: tb/tb_thermocouple_scanner.sv
// tb_thermocouple_scanner
//   Directed bench: an SPI master model answers each request from a table of
//   frames with hand-decoded expected fields; expected results go into a
//   scoreboard queue that an independent monitor drains on every
//   sample_valid / timeout_err strobe.
module tb_thermocouple_scanner;

  localparam int NCH     = 4;
  localparam int STARTUP = 10;
  localparam int PERIOD  = 8;
  localparam int TIMEOUT = 20;
  localparam int CBITS   = 10;
  localparam int CHW     = 2;
  localparam int NVEC    = 10;

  logic           clk;
  logic           rst;
  logic           spi_not_busy;
  logic [31:0]    spi_rx_data;
  logic           spi_ena;
  logic [CHW-1:0] spi_sel;
  logic [13:0]    tc_temp_data;
  logic [11:0]    junction_temp_data;
  logic [3:0]     fault_bits;
  logic [CHW-1:0] sample_ch;
  logic           sample_valid;
  logic [NCH-1:0] fault_mask;
  logic           timeout_err;

  thermocouple_scanner #(
    .NCH            (NCH),
    .STARTUP_CYCLES (STARTUP),
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CBITS          (CBITS),
    .CHW            (CHW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .spi_not_busy       (spi_not_busy),
    .spi_rx_data        (spi_rx_data),
    .spi_ena            (spi_ena),
    .spi_sel            (spi_sel),
    .tc_temp_data       (tc_temp_data),
    .junction_temp_data (junction_temp_data),
    .fault_bits         (fault_bits),
    .sample_ch          (sample_ch),
    .sample_valid       (sample_valid),
    .fault_mask         (fault_mask),
    .timeout_err        (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_SAMPLE, K_TIMEOUT, K_NONE} kind_t;

  typedef struct {
    int          id;
    logic [31:0] frame;
    int          len;     // cycles the SPI model keeps spi_not_busy low
    int          sel;     // channel expected on spi_sel at the request
    kind_t       kind;
    logic [1:0]  ch_out;  // expected sample_ch after the event
    logic [13:0] tc;
    logic [11:0] jt;
    logic [3:0]  fb;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[NVEC];
  vec_t sb[$];

  int errors = 0;
  int checks = 0;
  int events = 0;
  int req_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // SPI master model: accepts a request at the negedge it sees spi_ena high,
  // holds busy for the table's length, then presents the frame.
  vec_t mv;
  initial begin
    //                id frame          len sel kind       ch  tc       jt       fb     mask
    vecs[0] = '{0, 32'h1F40_0A52,  5, 0, K_SAMPLE,  2'd0, 14'h07D0, 12'h0A5, 4'h2, 4'b0000};
    vecs[1] = '{1, 32'h0C80_1900,  3, 1, K_SAMPLE,  2'd1, 14'h0320, 12'h190, 4'h0, 4'b0000};
    vecs[2] = '{2, 32'h0641_1235,  4, 2, K_SAMPLE,  2'd2, 14'h0190, 12'h123, 4'hD, 4'b0100};
    vecs[3] = '{3, 32'h1000_0000,  4, 3, K_SAMPLE,  2'd3, 14'h0400, 12'h000, 4'h0, 4'b0100};
    vecs[4] = '{4, 32'h0000_FFF7,  2, 0, K_SAMPLE,  2'd0, 14'h0000, 12'hFFF, 4'h7, 4'b0100};
    // Channel 1 stalls past the timeout; outputs keep entry 4's capture.
    vecs[5] = '{5, 32'hDEAD_BEEF, 25, 1, K_TIMEOUT, 2'd0, 14'h0000, 12'hFFF, 4'h7, 4'b0110};
    // Frame returns on exactly the timeout edge: capture must win.
    vecs[6] = '{6, 32'h0320_0008, 20, 2, K_SAMPLE,  2'd2, 14'h00C8, 12'h000, 4'h0, 4'b0110};
    vecs[7] = '{7, 32'h0001_0000,  2, 3, K_SAMPLE,  2'd3, 14'h0000, 12'h000, 4'h8, 4'b1110};
    // Abandoned by a reset in the middle of BUSY.
    vecs[8] = '{8, 32'h2000_0010,  5, 0, K_NONE,    2'd0, 14'h0000, 12'h000, 4'h0, 4'b0000};
    vecs[9] = '{9, 32'h1F40_0A52,  5, 0, K_SAMPLE,  2'd0, 14'h07D0, 12'h0A5, 4'h2, 4'b0000};

    spi_not_busy = 1'b1;
    spi_rx_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (spi_ena && spi_not_busy && !rst) begin
        if (req_idx < NVEC) begin
          mv = vecs[req_idx];
          check($sformatf("spi_sel_req%0d", req_idx), 32'(spi_sel), 32'(mv.sel));
        end else begin
          mv = '{req_idx, 32'h0, 2, 0, K_NONE, 2'd0, 14'h0, 12'h0, 4'h0, 4'h0};
        end
        if (mv.kind != K_NONE) sb.push_back(mv);
        req_idx++;
        spi_not_busy = 1'b0;
        repeat (mv.len) @(negedge clk);
        spi_rx_data  = mv.frame;
        spi_not_busy = 1'b1;
      end
    end
  end

  // Monitor: measures latency from the spi_ena fall (BUSY entry) and checks
  // each strobe against the scoreboard head.
  vec_t mon_v;
  int   ncyc = 0;
  int   fall_cyc = 0;
  logic prev_ena = 1'b0;
  logic width_pending = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (width_pending) begin
        check("strobe_width", 32'({sample_valid, timeout_err}), 32'h0);
        width_pending = 1'b0;
      end
      if (prev_ena && !spi_ena) fall_cyc = ncyc;
      prev_ena = spi_ena;
      if (sample_valid || timeout_err) begin
        events++;
        width_pending = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got sample_valid=%0b timeout_err=%0b, expected none",
                   sample_valid, timeout_err);
        end else begin
          mon_v = sb.pop_front();
          check($sformatf("sample_valid_%0d", mon_v.id), 32'(sample_valid), 32'(mon_v.kind == K_SAMPLE));
          check($sformatf("timeout_err_%0d", mon_v.id), 32'(timeout_err), 32'(mon_v.kind == K_TIMEOUT));
          check($sformatf("sample_ch_%0d", mon_v.id), 32'(sample_ch), 32'(mon_v.ch_out));
          check($sformatf("tc_temp_%0d", mon_v.id), 32'(tc_temp_data), 32'(mon_v.tc));
          check($sformatf("junction_temp_%0d", mon_v.id), 32'(junction_temp_data), 32'(mon_v.jt));
          check($sformatf("fault_bits_%0d", mon_v.id), 32'(fault_bits), 32'(mon_v.fb));
          check($sformatf("fault_mask_%0d", mon_v.id), 32'(fault_mask), 32'(mon_v.mask));
          check($sformatf("latency_%0d", mon_v.id), 32'(ncyc - fall_cyc),
                32'((mon_v.kind == K_TIMEOUT) ? TIMEOUT : mon_v.len));
        end
      end
    end
  end

  // Holds rst over one rising edge, checks the cleared outputs, releases it,
  // and counts rising edges until the first request appears.
  task automatic do_reset(input string tag);
    int n;
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_spi_ena"},      32'(spi_ena), 32'h0);
    check({tag, "_spi_sel"},      32'(spi_sel), 32'h0);
    check({tag, "_strobes"},      32'({sample_valid, timeout_err}), 32'h0);
    check({tag, "_data"},         32'({tc_temp_data, junction_temp_data, fault_bits}), 32'h0);
    check({tag, "_sample_ch"},    32'(sample_ch), 32'h0);
    check({tag, "_fault_mask"},   32'(fault_mask), 32'h0);
    rst = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (spi_ena) begin
        n = i;
        break;
      end
    end
    check({tag, "_first_spi_ena_edge"}, 32'(n), 32'(STARTUP + 1));
  endtask

  task automatic wait_events(input int n, input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (events >= n) break;
      @(negedge clk);
    end
    check(tag, 32'(events), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    do_reset("power_up");

    wait_events(8, "events_before_reset");

    for (int i = 0; i < 500; i++) begin
      if (req_idx >= 9) break;
      @(negedge clk);
    end
    check("reset_txn_issued", 32'(req_idx), 32'd9);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!spi_ena) break;
    end
    @(negedge clk);
    do_reset("mid_busy");

    wait_events(9, "events_after_reset");
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    summary();
    $finish;
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion by 100000 ns, expected completion");
    summary();
    $finish;
  end

endmodule
